// File: rtl/game_phase_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_phase_if
//  Description : Control/status bundle between the game-phase sequencer and
//                the logic that drives it (tick, start, pause in; phase
//                status out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_phase_if #(
  parameter int TW = 8
);
  logic          tick;
  logic          start;
  logic          pause;
  logic [1:0]    game_begin;
  logic [TW-1:0] time_left;
  logic          phase_pulse;
  logic          running;

  // Stimulus / consumer side: drives the time base and buttons.
  modport master (
    output tick, start, pause,
    input  game_begin, time_left, phase_pulse, running
  );

  // Sequencer side.
  modport slave (
    input  tick, start, pause,
    output game_begin, time_left, phase_pulse, running
  );
endinterface
`default_nettype wire

// File: rtl/game_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_phase_ctrl
//  Description : Game-phase sequencer IDLE -> COUNT -> PLAY -> OVER, timed in
//                1 s ticks, with start/restart, pause, optional timed
//                game-over hold and a time-remaining output.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_phase_ctrl #(
  parameter int COUNTDOWN_S = 4,
  parameter int PLAY_S      = 30,
  parameter int OVER_HOLD_S = 0,
  parameter int AUTO_START  = 1,
  parameter int TW          = 8
) (
  input  logic         clk,
  input  logic         reset,
  game_phase_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COUNT = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [TW-1:0] COUNT_LOAD = TW'(COUNTDOWN_S);
  localparam logic [TW-1:0] PLAY_LOAD  = TW'(PLAY_S);
  localparam logic [TW-1:0] OVER_LOAD  = TW'(OVER_HOLD_S);
  localparam logic [TW-1:0] ONE        = TW'(1);

  // A zero-length countdown makes "start a game" land directly in PLAY.
  localparam logic [1:0]    ENTRY_STATE = (COUNTDOWN_S == 0) ? ST_PLAY   : ST_COUNT;
  localparam logic [TW-1:0] ENTRY_LOAD  = (COUNTDOWN_S == 0) ? PLAY_LOAD : COUNT_LOAD;
  localparam bit            AUTO        = (AUTO_START != 0);
  localparam bit            OVER_TIMED  = (OVER_HOLD_S != 0);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] time_left;
  logic [TW-1:0] time_left_nxt;
  logic [1:0]    game_begin;
  logic [1:0]    game_begin_nxt;
  logic          phase_pulse;
  logic          running;
  logic          start_q;
  logic          start_edge;
  logic          tick_run;

  assign start_edge = bus.start & ~start_q;
  // Timer advances in COUNT/PLAY only when not paused; a paused tick is dropped.
  assign tick_run   = bus.tick & ~bus.pause;

  // Next-state and next-timer decision for the current phase.
  always_comb begin
    state_nxt     = state;
    time_left_nxt = time_left;
    case (state)
      ST_IDLE: begin
        if (AUTO || start_edge) begin
          state_nxt     = ENTRY_STATE;
          time_left_nxt = ENTRY_LOAD;
        end
      end
      ST_COUNT: begin
        if (tick_run) begin
          if (time_left > ONE) begin
            time_left_nxt = time_left - ONE;
          end else begin
            state_nxt     = ST_PLAY;
            time_left_nxt = PLAY_LOAD;
          end
        end
      end
      ST_PLAY: begin
        if (tick_run) begin
          if (time_left > ONE) begin
            time_left_nxt = time_left - ONE;
          end else begin
            state_nxt     = ST_OVER;
            time_left_nxt = OVER_LOAD;
          end
        end
      end
      default: begin
        // OVER: a restart press beats a coincident tick; the hold ignores pause.
        if (start_edge) begin
          state_nxt     = ENTRY_STATE;
          time_left_nxt = ENTRY_LOAD;
        end else if (OVER_TIMED && bus.tick) begin
          if (time_left > ONE) begin
            time_left_nxt = time_left - ONE;
          end else begin
            state_nxt     = ST_IDLE;
            time_left_nxt = '0;
          end
        end
      end
    endcase
  end

  // Phase code seen by the mole/score/display logic, decoded from the next state.
  always_comb begin
    game_begin_nxt = 2'b00;
    case (state_nxt)
      ST_PLAY: game_begin_nxt = 2'b01;
      ST_OVER: game_begin_nxt = 2'b10;
      default: game_begin_nxt = 2'b00;
    endcase
  end

  // All state and outputs register together; start_q resets high so a held
  // button through reset is not seen as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      time_left   <= '0;
      game_begin  <= 2'b00;
      phase_pulse <= 1'b0;
      running     <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      state       <= state_nxt;
      time_left   <= time_left_nxt;
      game_begin  <= game_begin_nxt;
      phase_pulse <= (state_nxt != state);
      running     <= (state_nxt == ST_COUNT) || (state_nxt == ST_PLAY);
      start_q     <= bus.start;
    end
  end

  assign bus.game_begin  = game_begin;
  assign bus.time_left   = time_left;
  assign bus.phase_pulse = phase_pulse;
  assign bus.running     = running;

endmodule
`default_nettype wire
